// File: rtl/psg_bus_arbiter.sv
// Shares the YM2149 register bus between CPU (req/ack) and player (FIFO); `PSG_ARB_SHADOW_EN adds a redundant-write filter.
// Latency: grant in IDLE, ADDR/DATA HOLD_CYCLES each, GAP/ack at 2H+1; one access per 2H+2 cycles.
// Backpressure: ply_ready = !fifo_full; CPU holds cpu_req until cpu_ack.
module psg_bus_arbiter #(
  parameter int FIFO_DEPTH  = 8,
  parameter int HOLD_CYCLES = 1
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        cpu_req,
  input  logic                        cpu_we,
  input  logic [3:0]                  cpu_addr,
  input  logic [7:0]                  cpu_wdata,
  output logic                        cpu_ack,
  output logic [7:0]                  cpu_rdata,
  input  logic                        ply_valid,
  input  logic [3:0]                  ply_addr,
  input  logic [7:0]                  ply_data,
  output logic                        ply_ready,
  input  logic                        ply_flush,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        psg_bdir,
  output logic                        psg_bc,
  output logic [7:0]                  psg_di,
  input  logic [7:0]                  psg_do,
  output logic                        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_GAP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] hold_cnt, hold_cnt_nxt;
  logic          hold_last;

  logic [11:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   level;
  logic          fifo_empty, fifo_full, push, pop;
  logic [11:0]   head;

  logic          own_cpu_q, we_q, last_ply;
  logic [3:0]    addr_q;
  logic [7:0]    data_q;

  logic          cpu_cand, ply_cand, grant, grant_cpu, redundant;
  logic          sel_we;
  logic [3:0]    sel_addr;
  logic [7:0]    sel_data;
  logic          own_n, we_n;
  logic [3:0]    addr_n;
  logic [7:0]    data_n;
  logic          bdir_n, bc_n, ack_n;
  logic [7:0]    di_n;

  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == (AW+1)'(FIFO_DEPTH));
  assign ply_ready  = !fifo_full;
  assign fifo_level = level;
  assign head       = fifo_mem[rd_ptr];
  assign push       = ply_valid && !fifo_full && !ply_flush;
  assign hold_last  = (hold_cnt == CW'(HOLD_CYCLES - 1));
  assign busy       = (state != S_IDLE);

  // cpu_ack high means a redundant CPU grant is completing; its req is still up.
  assign cpu_cand  = cpu_req && !cpu_ack;
  assign ply_cand  = !fifo_empty;
  assign grant     = (state == S_IDLE) && (cpu_cand || ply_cand);
  assign grant_cpu = grant && cpu_cand && (!ply_cand || last_ply);
  assign pop       = grant && !grant_cpu;
  assign sel_we    = grant_cpu ? cpu_we    : 1'b1;
  assign sel_addr  = grant_cpu ? cpu_addr  : head[11:8];
  assign sel_data  = grant_cpu ? cpu_wdata : head[7:0];

`ifdef PSG_ARB_SHADOW_EN
  logic [7:0] shadow [16];

  // Register 13 always passes: writing it restarts the envelope.
  assign redundant = grant && sel_we && (sel_addr != 4'd13) && (shadow[sel_addr] == sel_data);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < 16; i++) shadow[i] <= (i == 7) ? 8'hFF : 8'h00;
    end else if (state == S_GAP && we_q) begin
      shadow[addr_q] <= data_q;
    end
  end
`else
  assign redundant = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    case (state)
      S_IDLE: begin
        hold_cnt_nxt = '0;
        if (grant && !redundant) state_nxt = S_ADDR;
      end
      S_ADDR: begin
        if (hold_last) begin
          state_nxt    = S_DATA;
          hold_cnt_nxt = '0;
        end else begin
          hold_cnt_nxt = hold_cnt + CW'(1);
        end
      end
      S_DATA: begin
        if (hold_last) begin
          state_nxt    = S_GAP;
          hold_cnt_nxt = '0;
        end else begin
          hold_cnt_nxt = hold_cnt + CW'(1);
        end
      end
      S_GAP:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bus outputs are decoded from the next state so they register cleanly.
  always_comb begin
    own_n  = grant ? grant_cpu : own_cpu_q;
    we_n   = grant ? sel_we    : we_q;
    addr_n = grant ? sel_addr  : addr_q;
    data_n = grant ? sel_data  : data_q;
    bdir_n = 1'b0;
    bc_n   = 1'b0;
    di_n   = 8'h00;
    case (state_nxt)
      S_ADDR: begin
        bdir_n = 1'b1;
        bc_n   = 1'b1;
        di_n   = {4'h0, addr_n};
      end
      S_DATA: begin
        if (we_n) begin
          bdir_n = 1'b1;
          di_n   = data_n;
        end else begin
          bc_n = 1'b1;
        end
      end
      default: ;
    endcase
    ack_n = ((state_nxt == S_GAP) && own_n) || (redundant && grant_cpu);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= S_IDLE;
      hold_cnt  <= '0;
      own_cpu_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 4'h0;
      data_q    <= 8'h00;
      last_ply  <= 1'b1;
      psg_bdir  <= 1'b0;
      psg_bc    <= 1'b0;
      psg_di    <= 8'h00;
      cpu_ack   <= 1'b0;
      cpu_rdata <= 8'h00;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_cnt_nxt;
      own_cpu_q <= own_n;
      we_q      <= we_n;
      addr_q    <= addr_n;
      data_q    <= data_n;
      if (grant) last_ply <= !grant_cpu;
      psg_bdir  <= bdir_n;
      psg_bc    <= bc_n;
      psg_di    <= di_n;
      cpu_ack   <= ack_n;
      if (state == S_DATA && hold_last && !we_q) cpu_rdata <= psg_do;
    end
  end

  // Flush clears pointers; an already-granted player write keeps its latched copy.
  always_ff @(posedge CLK) begin
    if (RESET || ply_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr] <= {ply_addr, ply_data};
  end

endmodule

// File: tb/tb_psg_bus_arbiter.sv
// Directed bench for psg_bus_arbiter: a H=1 instance with a small PSG model and bus monitor,
// plus a H=8 instance used for FIFO fill/flush while its bus is held by a long CPU write.
module tb_psg_bus_arbiter;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;
  logic RESET;

  logic       cpu_req, cpu_we, cpu_ack, ply_valid, ply_ready, ply_flush;
  logic       psg_bdir, psg_bc, busy;
  logic [3:0] cpu_addr, ply_addr, fifo_level;
  logic [7:0] cpu_wdata, cpu_rdata, ply_data, psg_di, psg_do;

  logic       b_cpu_req, b_cpu_we, b_cpu_ack, b_ply_valid, b_ply_ready, b_ply_flush;
  logic       b_psg_bdir, b_psg_bc, b_busy;
  logic [3:0] b_cpu_addr, b_ply_addr, b_fifo_level;
  logic [7:0] b_cpu_wdata, b_cpu_rdata, b_ply_data, b_psg_di, b_psg_do;

  psg_bus_arbiter #(.FIFO_DEPTH(8), .HOLD_CYCLES(1)) dut (
    .CLK(CLK), .RESET(RESET),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ply_valid(ply_valid), .ply_addr(ply_addr), .ply_data(ply_data), .ply_ready(ply_ready),
    .ply_flush(ply_flush), .fifo_level(fifo_level),
    .psg_bdir(psg_bdir), .psg_bc(psg_bc), .psg_di(psg_di), .psg_do(psg_do), .busy(busy)
  );

  psg_bus_arbiter #(.FIFO_DEPTH(8), .HOLD_CYCLES(8)) dut_h8 (
    .CLK(CLK), .RESET(RESET),
    .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
    .cpu_ack(b_cpu_ack), .cpu_rdata(b_cpu_rdata),
    .ply_valid(b_ply_valid), .ply_addr(b_ply_addr), .ply_data(b_ply_data), .ply_ready(b_ply_ready),
    .ply_flush(b_ply_flush), .fifo_level(b_fifo_level),
    .psg_bdir(b_psg_bdir), .psg_bc(b_psg_bc), .psg_di(b_psg_di), .psg_do(b_psg_do), .busy(b_busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  // PSG model: latch address on 11, write on 10, DO reflects latched register.
  logic [7:0] mreg [16];
  logic [3:0] madr;
  always @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < 16; i++) mreg[i] <= (i == 7) ? 8'hFF : 8'h00;
      madr <= 4'h0;
    end else begin
      if ({psg_bdir, psg_bc} == 2'b11) madr <= psg_di[3:0];
      if ({psg_bdir, psg_bc} == 2'b10) mreg[madr] <= psg_di;
    end
  end
  assign psg_do = mreg[madr];

  // Bus monitor for the H=1 instance: records each write and each sequence start cycle.
  logic [1:0]  prev_bus = 2'b00;
  logic [3:0]  mon_addr = 4'h0;
  logic [11:0] wr_q [$];
  int          start_q [$];
  always @(negedge CLK) begin
    if ({psg_bdir, psg_bc} == 2'b11 && prev_bus != 2'b11) begin
      start_q.push_back(cyc);
      mon_addr = psg_di[3:0];
    end
    if ({psg_bdir, psg_bc} == 2'b10 && prev_bus != 2'b10) wr_q.push_back({mon_addr, psg_di});
    prev_bus = {psg_bdir, psg_bc};
  end

  task automatic do_reset;
    RESET = 1'b1;
    step;
    step;
    RESET = 1'b0;
    wr_q.delete();
    start_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [11:0] exp3 [7];
  int acks, n55, n13;

  initial begin
    RESET = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    ply_valid = 0; ply_addr = 0; ply_data = 0; ply_flush = 0;
    b_cpu_req = 0; b_cpu_we = 0; b_cpu_addr = 0; b_cpu_wdata = 0;
    b_ply_valid = 0; b_ply_addr = 0; b_ply_data = 0; b_ply_flush = 0; b_psg_do = 8'h00;
    exp3 = '{12'h1C1, 12'h2A0, 12'h1C2, 12'h3A1, 12'h1C3, 12'h4A2, 12'h1C4};

    // Reset state
    do_reset;
    check("rst_bus", {psg_bdir, psg_bc}, 2'b00);
    check("rst_di", psg_di, 8'h00);
    check("rst_ack", cpu_ack, 1'b0);
    check("rst_rdata", cpu_rdata, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_level", fifo_level, 4'd0);
    check("rst_ready", ply_ready, 1'b1);

    // CPU write reg8 = 0x0F
    cpu_req = 1; cpu_we = 1; cpu_addr = 4'd8; cpu_wdata = 8'h0F;
    step;
    check("wr_c1_bus", {psg_bdir, psg_bc}, 2'b11);
    check("wr_c1_di", psg_di, 8'h08);
    check("wr_c1_busy", busy, 1'b1);
    step;
    check("wr_c2_bus", {psg_bdir, psg_bc}, 2'b10);
    check("wr_c2_di", psg_di, 8'h0F);
    check("wr_c2_ack", cpu_ack, 1'b0);
    step;
    check("wr_c3_bus", {psg_bdir, psg_bc}, 2'b00);
    check("wr_c3_ack", cpu_ack, 1'b1);
    cpu_req = 0;
    step;
    check("wr_c4_ack", cpu_ack, 1'b0);
    check("wr_c4_busy", busy, 1'b0);

    // CPU read reg7 (model holds 0xFF)
    cpu_req = 1; cpu_we = 0; cpu_addr = 4'd7;
    step;
    check("rd_c1_bus", {psg_bdir, psg_bc}, 2'b11);
    check("rd_c1_di", psg_di, 8'h07);
    step;
    check("rd_c2_bus", {psg_bdir, psg_bc}, 2'b01);
    check("rd_c2_di", psg_di, 8'h00);
    step;
    check("rd_c3_bus", {psg_bdir, psg_bc}, 2'b00);
    check("rd_c3_ack", cpu_ack, 1'b1);
    check("rd_c3_rdata", cpu_rdata, 8'hFF);
    cpu_req = 0;
    step;
    step;
    check("rd_hold_rdata", cpu_rdata, 8'hFF);
    check("rd_hold_ack", cpu_ack, 1'b0);

    // Alternation: CPU held high against three queued player writes
    do_reset;
    cpu_req = 1; cpu_we = 1; cpu_addr = 4'd1; cpu_wdata = 8'hC1;
    acks = 0;
    for (int i = 0; i < 40 && acks < 4; i++) begin
      if (i < 3) begin
        ply_valid = 1; ply_addr = 4'(2 + i); ply_data = 8'(8'hA0 + i);
      end else begin
        ply_valid = 0;
      end
      step;
      if (cpu_ack) begin
        acks++;
        cpu_wdata = cpu_wdata + 8'h01;
        if (acks == 4) cpu_req = 0;
      end
    end
    ply_valid = 0;
    step;
    step;
    check("alt_acks", acks, 4);
    check("alt_count", wr_q.size(), 7);
    for (int i = 0; i < 7 && i < wr_q.size(); i++) check($sformatf("alt_wr%0d", i), wr_q[i], exp3[i]);
    for (int i = 1; i < start_q.size(); i++) check($sformatf("alt_gap%0d", i), start_q[i] - start_q[i-1], 4);

    // FIFO fill / overflow / flush on the H=8 instance while its CPU write holds the bus
    do_reset;
    b_cpu_req = 1; b_cpu_we = 1; b_cpu_addr = 4'd5; b_cpu_wdata = 8'h11;
    for (int c = 1; c <= 18; c++) begin
      step;
      if (c == 8) begin
        check("h8_c8_bus", {b_psg_bdir, b_psg_bc}, 2'b11);
        check("h8_c8_di", b_psg_di, 8'h05);
        check("h8_c8_level", b_fifo_level, 4'd7);
        check("h8_c8_ready", b_ply_ready, 1'b1);
      end
      if (c == 9) begin
        check("h8_c9_bus", {b_psg_bdir, b_psg_bc}, 2'b10);
        check("h8_c9_di", b_psg_di, 8'h11);
        check("full_level", b_fifo_level, 4'd8);
        check("full_ready", b_ply_ready, 1'b0);
      end
      if (c == 10) check("ovf_level", b_fifo_level, 4'd8);
      if (c == 11) begin
        check("flush_level", b_fifo_level, 4'd0);
        check("flush_ready", b_ply_ready, 1'b1);
      end
      if (c == 12) check("push_level", b_fifo_level, 4'd1);
      if (c == 13) check("flush_push_level", b_fifo_level, 4'd0);
      if (c == 16) check("h8_c16_bus", {b_psg_bdir, b_psg_bc}, 2'b10);
      if (c == 17) begin
        check("h8_c17_bus", {b_psg_bdir, b_psg_bc}, 2'b00);
        check("h8_c17_ack", b_cpu_ack, 1'b1);
      end
      if (c == 18) begin
        check("h8_c18_busy", b_busy, 1'b0);
        check("h8_c18_rdata", b_cpu_rdata, 8'h00);
      end
      b_ply_valid = (c <= 12);
      b_ply_flush = (c == 10 || c == 12);
      b_ply_addr  = 4'(c);
      b_ply_data  = 8'(c);
      if (c == 17) b_cpu_req = 0;
    end
    b_ply_valid = 0; b_ply_flush = 0;

    // Reset during DATA of a CPU write, with two player entries queued
    do_reset;
    cpu_req = 1; cpu_we = 1; cpu_addr = 4'd9; cpu_wdata = 8'h0A;
    ply_valid = 1; ply_addr = 4'd1; ply_data = 8'h33;
    step;
    check("ab_c1_bus", {psg_bdir, psg_bc}, 2'b11);
    ply_addr = 4'd2; ply_data = 8'h44;
    step;
    ply_valid = 0;
    check("ab_c2_bus", {psg_bdir, psg_bc}, 2'b10);
    check("ab_c2_level", fifo_level, 4'd2);
    RESET = 1; cpu_req = 0;
    step;
    RESET = 0;
    check("ab_c3_bus", {psg_bdir, psg_bc}, 2'b00);
    check("ab_c3_di", psg_di, 8'h00);
    check("ab_c3_busy", busy, 1'b0);
    check("ab_c3_ack", cpu_ack, 1'b0);
    check("ab_c3_level", fifo_level, 4'd0);
    step;
    check("ab_c4_ack", cpu_ack, 1'b0);
    check("ab_c4_busy", busy, 1'b0);

    // Player writes reg0=0x55 twice, reg13=0x0E twice
    do_reset;
    for (int i = 0; i < 4; i++) begin
      ply_valid = 1;
      ply_addr  = (i < 2) ? 4'd0 : 4'd13;
      ply_data  = (i < 2) ? 8'h55 : 8'h0E;
      step;
    end
    ply_valid = 0;
    for (int i = 0; i < 30; i++) step;
    n55 = 0;
    n13 = 0;
    foreach (wr_q[i]) begin
      if (wr_q[i] == 12'h055) n55++;
      if (wr_q[i][11:8] == 4'd13) n13++;
    end
`ifdef PSG_ARB_SHADOW_EN
    check("shd_total", wr_q.size(), 3);
    check("shd_reg0", n55, 1);
`else
    check("shd_total", wr_q.size(), 4);
    check("shd_reg0", n55, 2);
`endif
    check("shd_reg13", n13, 2);
    check("shd_level", fifo_level, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
